mem_responder: RTL and testbench

- Byte-wide memory server: the responder end of the CPU core's fetch/load/store memory traffic.
- Replaces the core's internal byte array. Boots by accepting a program image byte-stream from the loader (SD path), then scans it for the code-section marker byte and publishes the code start address.
- After boot, serves one outstanding read/write request at a time with a programmable wait-state count emulating SDRAM latency.

---
 rtl/mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Brief   : Byte-wide memory server. Boots from a loaded program image, scans
//           it for the code-section marker, then serves single requests with
//           a fixed wait-state count.
// Rev     : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int         ADDR_WIDTH   = 23,
    parameter int         DEPTH        = 8000000,
    parameter int         READ_LATENCY = 2,
    parameter logic [7:0] MARKER       = 8'd14
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    input  logic                  load_done,
    output logic                  load_ready,
    output logic                  load_overflow,
    output logic [31:0]           code_start,
    output logic                  code_start_valid,
    output logic                  scan_miss,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_error
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PTR_W = $clog2(DEPTH + 1);
    localparam int c_CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [c_PTR_W-1:0]  c_DEPTH_P  = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_INIT = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ST_LOAD = 3'd0;
    localparam logic [2:0] c_ST_SCAN = 3'd1;
    localparam logic [2:0] c_ST_IDLE = 3'd2;
    localparam logic [2:0] c_ST_WAIT = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    logic [2:0]            r_state;
    logic [7:0]            r_mem [0:DEPTH-1];
    logic [7:0]            r_rd_data;
    logic [c_PTR_W-1:0]    r_load_ptr;
    logic [c_PTR_W-1:0]    r_scan_addr;
    logic                  r_scan_vld;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [7:0]            r_wdata;
    logic [31:0]           r_code_start;
    logic                  r_code_start_valid;
    logic                  r_scan_miss;
    logic                  r_load_overflow;
    logic                  r_rsp_valid;
    logic [7:0]            r_rsp_rdata;
    logic                  r_rsp_error;

    logic                  w_req_ok;
    logic                  w_addr_ok;
    logic                  w_we;
    logic [c_IDX_W-1:0]    w_waddr;
    logic [7:0]            w_wdata;
    logic [c_IDX_W-1:0]    w_raddr;

    assign w_req_ok  = ({1'b0, req_addr} < c_DEPTH_A);
    assign w_addr_ok = ({1'b0, r_addr} < c_DEPTH_A);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (!reset) begin
            if (r_state == c_ST_LOAD && load_valid && r_load_ptr != c_DEPTH_P) begin
                w_we    = 1'b1;
                w_waddr = r_load_ptr[c_IDX_W-1:0];
                w_wdata = load_data;
            end else if (r_state == c_ST_IDLE && req_valid && req_write && w_req_ok) begin
                w_we    = 1'b1;
                w_waddr = req_addr[c_IDX_W-1:0];
                w_wdata = req_wdata;
            end
        end
    end

    // Single read port: the scan pointer while scanning, otherwise the request
    // address, so read data is ready one edge after accept for any latency.
    always_comb begin
        case (r_state)
            c_ST_SCAN: w_raddr = r_scan_addr[c_IDX_W-1:0];
            c_ST_IDLE: w_raddr = req_addr[c_IDX_W-1:0];
            default:   w_raddr = r_addr[c_IDX_W-1:0];
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[w_raddr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state            <= c_ST_LOAD;
            r_load_ptr         <= '0;
            r_scan_addr        <= '0;
            r_scan_vld         <= 1'b0;
            r_cnt              <= '0;
            r_addr             <= '0;
            r_write            <= 1'b0;
            r_wdata            <= '0;
            r_code_start       <= '0;
            r_code_start_valid <= 1'b0;
            r_scan_miss        <= 1'b0;
            r_load_overflow    <= 1'b0;
            r_rsp_valid        <= 1'b0;
            r_rsp_rdata        <= '0;
            r_rsp_error        <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (load_valid) begin
                        if (r_load_ptr == c_DEPTH_P) begin
                            r_load_overflow <= 1'b1;
                        end else begin
                            r_load_ptr <= r_load_ptr + c_PTR_ONE;
                        end
                    end
                    if (load_done) begin
                        r_state     <= c_ST_SCAN;
                        r_scan_addr <= '0;
                        r_scan_vld  <= 1'b0;
                    end
                end
                // r_rd_data holds byte r_scan_addr-1 whenever r_scan_vld is set
                c_ST_SCAN: begin
                    if (r_scan_vld && r_rd_data == MARKER) begin
                        r_code_start       <= 32'(r_scan_addr);
                        r_code_start_valid <= 1'b1;
                        r_state            <= c_ST_IDLE;
                    end else if (r_scan_addr == r_load_ptr) begin
                        r_code_start       <= '0;
                        r_scan_miss        <= 1'b1;
                        r_code_start_valid <= 1'b1;
                        r_state            <= c_ST_IDLE;
                    end else begin
                        r_scan_addr <= r_scan_addr + c_PTR_ONE;
                        r_scan_vld  <= 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= (READ_LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= !w_addr_ok;
                    r_rsp_rdata <= r_write ? r_wdata : (w_addr_ok ? r_rd_data : 8'h00);
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

    assign load_ready       = (r_state == c_ST_LOAD);
    assign req_ready        = (r_state == c_ST_IDLE);
    assign load_overflow    = r_load_overflow;
    assign code_start       = r_code_start;
    assign code_start_valid = r_code_start_valid;
    assign scan_miss        = r_scan_miss;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rsp_rdata;
    assign rsp_error        = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Self-checking bench for mem_responder against a cycle-level
//           behavioural model, plus literal expectations for key scenarios.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int         AW  = 10;
    localparam int         DEP = 256;
    localparam int         LAT = 2;
    localparam logic [7:0] MK  = 8'd14;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic          reset, load_valid, load_done, req_valid, req_write;
    logic [7:0]    load_data, req_wdata;
    logic [AW-1:0] req_addr;
    logic          load_ready, load_overflow, code_start_valid, scan_miss;
    logic          req_ready, rsp_valid, rsp_error;
    logic [31:0]   code_start;
    logic [7:0]    rsp_rdata;

    logic          s_reset, s_load_valid, s_load_done, s_req_valid, s_req_write;
    logic [7:0]    s_load_data, s_req_wdata;
    logic [AW-1:0] s_req_addr;
    logic          s_load_ready, s_load_overflow, s_code_start_valid, s_scan_miss;
    logic          s_req_ready, s_rsp_valid, s_rsp_error;
    logic [31:0]   s_code_start;
    logic [7:0]    s_rsp_rdata;

    mem_responder #(.ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(LAT), .MARKER(MK)) u_dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
        .load_ready(load_ready), .load_overflow(load_overflow),
        .code_start(code_start), .code_start_valid(code_start_valid), .scan_miss(scan_miss),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DEPTH(4), .READ_LATENCY(1), .MARKER(MK)) u_small (
        .CLOCK_50(CLOCK_50), .reset(s_reset),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_done(s_load_done),
        .load_ready(s_load_ready), .load_overflow(s_load_overflow),
        .code_start(s_code_start), .code_start_valid(s_code_start_valid), .scan_miss(s_scan_miss),
        .req_valid(s_req_valid), .req_write(s_req_write), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_error(s_rsp_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
        bit         err;
        bit         chk;
    } rsp_t;

    int         cyc = 0;
    int         phase = 0;          // 0 loading, 1 scanning, 2 serving
    int         m_ptr, m_cs, res_cs, done_edge, ready_from, mk_k, m_a;
    bit         m_ovf, m_csv, m_miss, res_miss;
    logic [7:0] m_mem [DEP];
    bit         m_known [DEP];
    rsp_t       q[$];
    rsp_t       m_r;

    always @(posedge CLOCK_50) begin
        cyc++;
        if (reset) begin
            phase = 0; m_ptr = 0; m_ovf = 0; m_csv = 0; m_miss = 0; m_cs = 0;
            q.delete();
        end else if (phase == 0) begin
            if (load_valid) begin
                if (m_ptr < DEP) begin
                    m_mem[m_ptr] = load_data; m_known[m_ptr] = 1; m_ptr++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (load_done) begin
                mk_k = -1;
                for (int i = 0; i < m_ptr; i++)
                    if (mk_k < 0 && m_mem[i] == MK) mk_k = i;
                if (mk_k >= 0) begin
                    done_edge = cyc + mk_k + 2; res_cs = mk_k + 1; res_miss = 0;
                end else begin
                    done_edge = cyc + m_ptr + 1; res_cs = 0; res_miss = 1;
                end
                phase = 1;
            end
        end else if (phase == 1) begin
            if (cyc == done_edge) begin
                m_csv = 1; m_cs = res_cs; m_miss = res_miss; phase = 2; ready_from = cyc + 1;
            end
        end else if (req_valid && cyc >= ready_from) begin
            m_a = int'(req_addr);
            m_r.err = (m_a >= DEP);
            if (req_write) begin
                if (!m_r.err) begin m_mem[m_a] = req_wdata; m_known[m_a] = 1; end
                m_r.data = req_wdata; m_r.chk = 1;
            end else begin
                m_r.data = m_r.err ? 8'h00 : m_mem[m_a];
                m_r.chk  = m_r.err || m_known[m_a];
            end
            m_r.due = cyc + LAT;
            q.push_back(m_r);
            ready_from = cyc + LAT + 1;
        end
    end

    // ---------------- compare process ----------------
    int         rsp_cnt = 0, last_cyc = 0;
    logic [7:0] last_data;
    logic       last_err;
    bit         exp_v;

    always @(negedge CLOCK_50) begin
        if (cyc > 0) begin
            check("load_ready", load_ready, phase == 0);
            check("req_ready", req_ready, phase == 2 && cyc + 1 >= ready_from);
            check("code_start_valid", code_start_valid, m_csv);
            check("code_start", code_start, m_cs);
            check("scan_miss", scan_miss, m_miss);
            check("load_overflow", load_overflow, m_ovf);
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            check("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                if (q[0].chk) check("rsp_rdata", rsp_rdata, q[0].data);
                check("rsp_error", rsp_error, q[0].err);
            end
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
            if (rsp_valid) begin
                rsp_cnt++; last_data = rsp_rdata; last_err = rsp_error; last_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] img_q[$];
    logic [7:0] tb_b;
    int done_cyc, boot_cyc, acc_cyc, a0, prev, img_sz, img_k, rad;

    task automatic step();
        @(posedge CLOCK_50); #1;
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    task automatic load_image(input bit merge_done, input bit gaps);
        for (int i = 0; i < img_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                load_valid = 0; req_valid = 1'($urandom_range(0, 1)); req_write = 1;
                req_addr = AW'($urandom); req_wdata = 8'($urandom); step();
            end
            load_valid = 1; load_data = img_q[i];
            load_done  = merge_done && (i == img_q.size() - 1);
            step();
        end
        load_valid = 0; req_valid = 0;
        if (!(merge_done && img_q.size() > 0)) begin load_done = 1; step(); end
        load_done = 0;
        done_cyc  = cyc;
    endtask

    task automatic wait_boot();
        int n = 0;
        while (!code_start_valid && n < 600) begin step(); n++; end
        check("boot_completes", code_start_valid, 1);
        boot_cyc = cyc;
    endtask

    task automatic request(input bit wr, input int addr, input logic [7:0] wd);
        int n = 0;
        req_valid = 1; req_write = wr; req_addr = AW'(addr); req_wdata = wd;
        @(negedge CLOCK_50);
        while (!req_ready && n < 50) begin @(negedge CLOCK_50); n++; end
        check("req_accepted", req_ready, 1);
        @(posedge CLOCK_50); #1;
        acc_cyc   = cyc;
        req_valid = 0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = 8'($urandom);
    endtask

    task automatic wait_rsp(input int p);
        int n = 0;
        while (rsp_cnt == p && n < 20) begin step(); n++; end
        check("rsp_arrives", rsp_cnt != p, 1);
    endtask

    task automatic small_read(input int addr);
        s_req_valid = 1; s_req_write = 0; s_req_addr = AW'(addr);
        check("small_req_ready", s_req_ready, 1);
        step();
        s_req_valid = 0;
        step();
        check("small_rsp_valid", s_rsp_valid, 1);
    endtask

    initial begin
        #1_000_000;
        n_checks++; n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        reset = 1; load_valid = 0; load_data = 0; load_done = 0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        s_reset = 1; s_load_valid = 0; s_load_data = 0; s_load_done = 0;
        s_req_valid = 0; s_req_write = 0; s_req_addr = 0; s_req_wdata = 0;
        step(); step();
        check("rst_load_ready", load_ready, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_csv", code_start_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        reset = 0;

        // marker at index 1
        img_q = '{8'hAA, 8'h0E, 8'h05, 8'h01};
        load_image(0, 0);
        wait_boot();
        check("s1_csv_latency", boot_cyc - done_cyc, 3);
        check("s1_code_start", code_start, 2);
        check("s1_scan_miss", scan_miss, 0);
        check("s1_load_ready", load_ready, 0);

        // read with a second request held during the busy window
        prev = rsp_cnt;
        request(0, 2, 8'h00);
        a0 = acc_cyc;
        request(0, 3, 8'h00);
        check("s3_second_accept", acc_cyc - a0, 3);
        check("s3_rdata", last_data, 8'h05);
        check("s3_err", last_err, 0);
        check("s3_rsp_edge", last_cyc - a0, 2);
        wait_rsp(prev + 1);
        check("s3_second_rdata", last_data, 8'h01);

        // write then read back
        request(1, 17, 8'hC3); wait_rsp(rsp_cnt);
        prev = rsp_cnt; request(1, 16, 8'h5A); wait_rsp(prev);
        check("s4_write_echo", last_data, 8'h5A);
        prev = rsp_cnt; request(0, 16, 8'h00); wait_rsp(prev);
        check("s4_read_back", last_data, 8'h5A);
        prev = rsp_cnt; request(0, 17, 8'h00); wait_rsp(prev);
        check("s4_neighbour", last_data, 8'hC3);

        // out of range must not alias
        prev = rsp_cnt; request(1, 44, 8'h33); wait_rsp(prev);
        prev = rsp_cnt; request(1, 300, 8'h77); wait_rsp(prev);
        check("s5_oor_write_err", last_err, 1);
        prev = rsp_cnt; request(0, 300, 8'h00); wait_rsp(prev);
        check("s5_oor_rdata", last_data, 8'h00);
        check("s5_oor_err", last_err, 1);
        prev = rsp_cnt; request(0, 44, 8'h00); wait_rsp(prev);
        check("s5_no_alias", last_data, 8'h33);

        // image without marker
        do_reset();
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_image(0, 0);
        wait_boot();
        check("s2_miss_latency", boot_cyc - done_cyc, 5);
        check("s2_code_start", code_start, 0);
        check("s2_scan_miss", scan_miss, 1);
        check("s2_req_ready", req_ready, 1);

        // randomized images and request streams
        for (int r = 0; r < 3; r++) begin
            do_reset();
            img_q.delete();
            img_sz = $urandom_range(1, DEP);
            img_k  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, img_sz - 1));
            for (int i = 0; i < img_sz; i++) begin
                tb_b = 8'($urandom);
                if ((img_k < 0 || i < img_k) && tb_b == MK) tb_b = MK + 8'd1;
                if (i == img_k) tb_b = MK;
                img_q.push_back(tb_b);
            end
            load_image(1'($urandom_range(0, 1)), 1);
            wait_boot();
            for (int j = 0; j < 40; j++) begin
                rad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEP, 1023))
                                                   : int'($urandom_range(0, DEP - 1));
                request(1'($urandom_range(0, 1)), rad, 8'($urandom));
                repeat ($urandom_range(0, 2)) step();
            end
            repeat (4) step();
        end

        // reset while a request is waiting
        prev = rsp_cnt;
        request(0, 5, 8'h00);
        reset = 1; step(); reset = 0;
        check("s6_load_ready", load_ready, 1);
        check("s6_csv", code_start_valid, 0);
        repeat (5) step();
        check("s6_no_rsp", rsp_cnt, prev);
        img_q = '{8'h0E, 8'h22, 8'h33};
        load_image(1, 0);
        wait_boot();
        check("s6_code_start", code_start, 1);
        check("s6_latency", boot_cyc - done_cyc, 2);

        // empty image
        do_reset();
        img_q.delete();
        load_image(0, 0);
        wait_boot();
        check("empty_latency", boot_cyc - done_cyc, 1);
        check("empty_miss", scan_miss, 1);

        // DEPTH=4 instance: overflow and latency 1
        s_reset = 1; step(); s_reset = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("small_no_ovf_yet", s_load_overflow, 0);
            s_load_valid = 1; s_load_data = 8'(i + 1); step();
        end
        s_load_valid = 0; s_load_done = 1; step(); s_load_done = 0;
        check("small_overflow", s_load_overflow, 1);
        repeat (8) step();
        check("small_csv", s_code_start_valid, 1);
        check("small_miss", s_scan_miss, 1);
        small_read(3);
        check("small_rd3", s_rsp_rdata, 8'h04);
        small_read(0);
        check("small_rd0", s_rsp_rdata, 8'h01);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
